// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_pkg;

    typedef logic [31:0] word_t;

    localparam word_t NOP_INSTR = {4'b1110, 28'b0};

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction/PC buffer for the fetch queue: circular storage with wrapping
// pointers, an occupancy count and a single-cycle flush.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  push_data,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; validity is tracked solely by
    // count, so stale words are never observed and the array stays plain RAM.
    always_ff @(posedge clk_i) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register: sequential req/ack
// fetches, redirect/drain handling, FIFO buffering. FETCHQ_BYPASS_EN enables
// the same-cycle empty-queue bypass.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter int    PC_STEP  = 4
) (
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  logic  redirect_i,
    input  word_t redirect_pc_i,
    input  logic  stall_i,
    output logic  imem_req_o,
    output word_t imem_addr_o,
    input  logic  imem_ack_i,
    input  word_t imem_data_i,
    output word_t instr_o,
    output word_t instr_pc_o,
    output logic  instr_valid_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state, state_d;
    logic          req_d;
    word_t         addr_d;
    word_t         pend_pc, pend_pc_d;
    logic          xfer, pending, push, pop, bypass;
    logic          full, empty;
    logic [CW-1:0] count, count_next;
    fetch_entry_t  head;

    assign xfer    = imem_req_o && imem_ack_i;
    assign pending = imem_req_o && !imem_ack_i;

`ifdef FETCHQ_BYPASS_EN
    assign bypass = empty && (state == RUN) && !redirect_i && xfer;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that decode accepts immediately never enters the FIFO.
    assign pop        = !empty && !stall_i && !redirect_i;
    assign push       = xfer && (state == RUN) && !redirect_i && !(bypass && !stall_i);
    assign count_next = redirect_i ? '0 : count + CW'(push) - CW'(pop);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_i),
        .push_data ('{instr: imem_data_i, pc: imem_addr_o}),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        instr_valid_o = !empty;
        instr_o       = empty ? NOP_INSTR : head.instr;
        instr_pc_o    = empty ? '0 : head.pc;
        if (bypass) begin
            instr_valid_o = 1'b1;
            instr_o       = imem_data_i;
            instr_pc_o    = imem_addr_o;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state;
        req_d     = imem_req_o;
        addr_d    = imem_addr_o;
        pend_pc_d = pend_pc;
        case (state)
            RUN: begin
                if (redirect_i) begin
                    if (pending) begin
                        state_d   = DRAIN;
                        pend_pc_d = redirect_pc_i;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = redirect_pc_i;
                    end
                end else if (!pending) begin
                    if (xfer) addr_d = imem_addr_o + word_t'(PC_STEP);
                    req_d = (int'(count_next) < DEPTH);
                end
            end
            DRAIN: begin
                // The in-flight word belongs to the old path; wait it out, then restart.
                if (xfer) begin
                    state_d = RUN;
                    req_d   = 1'b1;
                    addr_d  = redirect_i ? redirect_pc_i : pend_pc;
                end else if (redirect_i) begin
                    pend_pc_d = redirect_pc_i;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= RUN;
            imem_req_o  <= 1'b0;
            imem_addr_o <= RESET_PC;
            pend_pc     <= '0;
        end else begin
            state       <= state_d;
            imem_req_o  <= req_d;
            imem_addr_o <= addr_d;
            pend_pc     <= pend_pc_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push && full && !pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          PC_STEP  = 4;
    localparam logic [31:0] NOP      = {4'b1110, 28'b0};
    localparam logic [31:0] BEEF     = 32'hDEAD_BEEF;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;

    always #5 clk_i = ~clk_i;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an in-order queue of fetched words, the outstanding
    // request, and a "waiting out a stale fetch" flag with its target.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      q[$];
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_drain;
    logic [31:0] m_pend;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic model_reset();
        q.delete();
        m_req   = 1'b0;
        m_addr  = RESET_PC;
        m_drain = 1'b0;
        m_pend  = '0;
    endtask

    task automatic cycle(input logic redir, input logic [31:0] rpc, input logic stall,
                         input logic ack, input logic [31:0] data);
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        xfer;
        logic        was_empty;
        logic        consumed;
        @(negedge clk_i);
        redirect_i    = redir;
        redirect_pc_i = rpc;
        stall_i       = stall;
        imem_ack_i    = ack;
        imem_data_i   = data;
        #1;
        xfer    = m_req && ack;
        e_valid = (q.size() > 0);
        e_instr = e_valid ? q[0].instr : NOP;
        e_pc    = e_valid ? q[0].pc : 32'h0;
`ifdef FETCHQ_BYPASS_EN
        if (!e_valid && !m_drain && !redir && xfer) begin
            e_valid = 1'b1;
            e_instr = data;
            e_pc    = m_addr;
        end
`endif
        check("req", imem_req_o, m_req);
        check("addr", imem_addr_o, m_addr);
        check("valid", instr_valid_o, e_valid);
        check("instr", instr_o, e_instr);
        check("pc", instr_pc_o, e_pc);

        if (redir) begin
            q.delete();
            if (m_req && !ack) begin
                m_drain = 1'b1;
                m_pend  = rpc;
            end else begin
                m_drain = 1'b0;
                m_req   = 1'b1;
                m_addr  = rpc;
            end
        end else if (m_drain) begin
            if (xfer) begin
                m_drain = 1'b0;
                m_req   = 1'b1;
                m_addr  = m_pend;
            end
        end else begin
            was_empty = (q.size() == 0);
            if (!was_empty && !stall) void'(q.pop_front());
            if (xfer) begin
                consumed = 1'b0;
`ifdef FETCHQ_BYPASS_EN
                consumed = was_empty && !stall;
`endif
                if (!consumed) q.push_back('{instr: data, pc: m_addr});
                m_addr = m_addr + 32'(PC_STEP);
            end
            if (!(m_req && !ack)) m_req = (q.size() < DEPTH);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic        r_redir;
        logic        r_stall;
        logic        r_ack;
        logic [31:0] r_pc;

        rst_n_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        stall_i       = 1'b0;
        imem_ack_i    = 1'b0;
        imem_data_i   = '0;
        model_reset();
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_req", imem_req_o, 1'b0);
        check("rst_valid", instr_valid_o, 1'b0);
        check("rst_instr", instr_o, NOP);
        check("rst_pc", instr_pc_o, 32'h0);
        check("rst_addr", imem_addr_o, RESET_PC);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        // Always-ack memory, no stall: sequential stream.
        repeat (12) cycle(1'b0, '0, 1'b0, 1'b1, mem_word(m_addr));

        // Hold stall: queue fills, request drops.
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b1, mem_word(m_addr));
        check("stall_req_drop", imem_req_o, 1'b0);
        check("stall_head_valid", instr_valid_o, 1'b1);
        repeat (15) cycle(1'b0, '0, 1'b0, 1'b1, mem_word(m_addr));

        // Redirect with three entries buffered and the request acked that cycle.
        for (int i = 0; i < 20 && !(q.size() == 3 && m_req); i++)
            cycle(1'b0, '0, q.size() < DEPTH, 1'b1, mem_word(m_addr));
        check("fill3_reached", (q.size() == 3) && m_req, 1'b1);
        cycle(1'b1, 32'h100, 1'b1, 1'b1, mem_word(m_addr));
        cycle(1'b0, '0, 1'b0, 1'b0, '0);
        check("redir_valid", instr_valid_o, 1'b0);
        check("redir_nop", instr_o, NOP);
        check("redir_addr", imem_addr_o, 32'h100);
        check("redir_req", imem_req_o, 1'b1);

        // Redirect while a request to 0x40 is outstanding with slow ack.
        cycle(1'b1, 32'h40, 1'b0, 1'b1, mem_word(m_addr));
        cycle(1'b1, 32'h200, 1'b0, 1'b0, '0);
        check("drain_addr0", imem_addr_o, 32'h40);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, '0);
            check("drain_hold", imem_addr_o, 32'h40);
        end
        cycle(1'b0, '0, 1'b0, 1'b1, BEEF);
        check("drain_ack_addr", imem_addr_o, 32'h40);
        check("no_beef_ack", instr_o == BEEF, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, '0);
        check("drain_target", imem_addr_o, 32'h200);
        check("drain_req", imem_req_o, 1'b1);
        check("no_beef_after", instr_o == BEEF, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b1, mem_word(m_addr));

        // Second redirect during DRAIN replaces the target.
        cycle(1'b1, 32'h40, 1'b0, 1'b1, mem_word(m_addr));
        cycle(1'b1, 32'h200, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, 1'b0, '0);
        cycle(1'b1, 32'h300, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, 1'b1, BEEF);
        cycle(1'b0, '0, 1'b0, 1'b0, '0);
        check("drain2_target", imem_addr_o, 32'h300);
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b1, mem_word(m_addr));

        // Address wrap past the top of the space.
        cycle(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, mem_word(m_addr));
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b1, mem_word(m_addr));

        // Asynchronous reset with the queue full.
        for (int i = 0; i < 20 && q.size() < DEPTH; i++)
            cycle(1'b0, '0, 1'b1, 1'b1, mem_word(m_addr));
        check("full_reached", q.size() == DEPTH, 1'b1);
        #2 rst_n_i = 1'b0;
        #1;
        check("arst_req", imem_req_o, 1'b0);
        check("arst_valid", instr_valid_o, 1'b0);
        check("arst_instr", instr_o, NOP);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b1, mem_word(m_addr));
        cycle(1'b0, '0, 1'b0, 1'b1, mem_word(m_addr));
        check("post_rst_addr", imem_addr_o, RESET_PC);
        check("post_rst_req", imem_req_o, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            r_redir = ($urandom_range(0, 19) == 0);
            r_stall = ($urandom_range(0, 2) == 0);
            r_ack   = (i < 1000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
            r_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                                  : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            cycle(r_redir, r_pc, r_stall, r_ack, mem_word(m_addr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
